// File: rtl/mdr_unit.sv
// Memory data register between the internal CPU bus (ib) and the external memory bus (eb).
// Loads from either bus and drives its stored value onto at most one bus at a time.
module mdr_unit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io,
  input  logic             w,
  inout  wire  [WIDTH-1:0] eb,
  inout  wire  [WIDTH-1:0] ib
);

  logic [WIDTH-1:0] mdr_q, mdr_d;
  logic             drive_eb, drive_ib;

  // Source bus value is stored as seen, including Z/X; no filtering.
  always_comb begin
    mdr_d = mdr_q;
    if (w) begin
      mdr_d = io ? eb : ib;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mdr_q <= '0;
    end else begin
      mdr_q <= mdr_d;
    end
  end

  // Drive is released during writes and reset so the source bus is never contended.
  always_comb begin
    drive_eb = reset & ~w & ~io;
    drive_ib = reset & ~w & io;
  end

  assign eb = drive_eb ? mdr_q : {WIDTH{1'bz}};
  assign ib = drive_ib ? mdr_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_mdr_unit.sv
// Bench for mdr_unit: directed scenarios with literal expectations, then random traffic
// checked every cycle against a behavioural register/bus model.
module tb_mdr_unit;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             io;
  logic             w;
  logic [WIDTH-1:0] eb_drv;
  logic [WIDTH-1:0] ib_drv;
  logic             eb_en;
  logic             ib_en;
  wire  [WIDTH-1:0] eb;
  wire  [WIDTH-1:0] ib;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  logic [WIDTH-1:0] model_q;
  logic             model_valid = 1'b0;

  always #5 clk = ~clk;

  mdr_unit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io),
    .w     (w),
    .eb    (eb),
    .ib    (ib)
  );

  // The bench drives every bus the register is supposed to leave alone, so a wrongly
  // driven or wrongly released bus shows up as a value that is not the expected one.
  assign eb_en = !(reset && !w && !io);
  assign ib_en = !(reset && !w && io);
  assign eb = eb_en ? eb_drv : {WIDTH{1'bz}};
  assign ib = ib_en ? ib_drv : {WIDTH{1'bz}};

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: reset clears, a write copies the chosen source bus, otherwise hold.
  always @(posedge clk) begin
    if (reset === 1'b0) begin
      model_q     <= '0;
      model_valid <= 1'b1;
    end else if (w) begin
      model_q <= io ? eb_drv : ib_drv;
    end
  end

  always @(negedge clk) begin
    logic [WIDTH-1:0] exp_eb, exp_ib;
    if (model_valid) begin
      exp_eb = (reset && !w && !io) ? model_q : eb_drv;
      exp_ib = (reset && !w && io)  ? model_q : ib_drv;
      check("model_eb", eb, exp_eb);
      check("model_ib", ib, exp_ib);
    end
  end

  task automatic apply(input logic r, input logic wv, input logic iov,
                       input logic [WIDTH-1:0] e, input logic [WIDTH-1:0] i);
    @(posedge clk);
    #1;
    reset  = r;
    w      = wv;
    io     = iov;
    eb_drv = e;
    ib_drv = i;
  endtask

  initial begin
    reset  = 1'b0;
    w      = 1'b0;
    io     = 1'b0;
    eb_drv = 8'h5a;
    ib_drv = 8'ha5;

    // Reset with w=0, io=0: both buses released, then eb shows the cleared register.
    @(negedge clk);
    check("reset_eb_released", eb, 8'h5a);
    check("reset_ib_released", ib, 8'ha5);
    apply(1'b1, 1'b0, 1'b0, 8'h00, 8'ha5);
    @(negedge clk);
    check("post_reset_eb", eb, 8'h00);

    // Load from eb; nothing driven by the register during the write.
    apply(1'b1, 1'b1, 1'b1, 8'h33, 8'hc3);
    @(negedge clk);
    check("load_eb_src", eb, 8'h33);
    check("load_eb_other", ib, 8'hc3);

    // Read onto ib for 10 cycles; eb carries whatever the bench puts there.
    for (int k = 0; k < 10; k++) begin
      apply(1'b1, 1'b0, 1'b1, WIDTH'($urandom), 8'h00);
      @(negedge clk);
      check("read_ib", ib, 8'h33);
      check("read_ib_eb_free", eb, eb_drv);
    end

    // Load from ib.
    apply(1'b1, 1'b1, 1'b0, 8'h96, 8'h11);
    @(negedge clk);
    check("load_ib_src", ib, 8'h11);
    check("load_ib_other", eb, 8'h96);

    // Read onto eb for 10 cycles.
    for (int k = 0; k < 10; k++) begin
      apply(1'b1, 1'b0, 1'b0, 8'h00, WIDTH'($urandom));
      @(negedge clk);
      check("read_eb", eb, 8'h11);
      check("read_eb_ib_free", ib, ib_drv);
    end

    // Reset coincident with a write from eb: reset wins.
    apply(1'b0, 1'b1, 1'b1, 8'haa, 8'h3c);
    apply(1'b1, 1'b0, 1'b1, 8'h77, 8'h00);
    @(negedge clk);
    check("reset_beats_write", ib, 8'h00);
    check("reset_beats_write_eb", eb, 8'h77);

    // Random traffic, checked by the model every cycle.
    for (int k = 0; k < 400; k++) begin
      apply(($urandom_range(15) != 0), 1'($urandom_range(1)), 1'($urandom_range(1)),
            WIDTH'($urandom), WIDTH'($urandom));
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
